// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Values above BCD_MAX saturate to all nines and raise overflow alongside done.
module bin_to_bcd_seq #(
    parameter int               BIN_W   = 20,
    parameter int               DIGITS  = 6,
    parameter logic [BIN_W-1:0] BCD_MAX = 20'd999_999
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    // One spare digit so inputs up to 2^BIN_W-1 convert cleanly before saturation.
    localparam int ACC_W  = 4*DIGITS + 4;
    localparam int PAIR_W = ACC_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [BIN_W-1:0]   bin_sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [PAIR_W-1:0]  pair_sh;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               last_shift;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        acc_adj = acc;
        for (int d = 0; d < DIGITS + 1; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
        pair_sh = {acc_adj, bin_sr} << 1;
    end

    assign last_shift = (state == SHIFT) && (cnt == LAST_CNT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_CNT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bin_sr   <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    bin_sr   <= bin_in;
                    acc      <= '0;
                    cnt      <= '0;
                    ovf_pend <= (bin_in > BCD_MAX);
                end
            end else begin
                acc    <= pair_sh[BIN_W +: ACC_W];
                bin_sr <= pair_sh[BIN_W-1:0];
                cnt    <= cnt + 1'b1;
                if (last_shift) begin
                    bcd_out  <= ovf_pend ? {DIGITS{4'h9}} : pair_sh[BIN_W +: 4*DIGITS];
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                end
            end
        end
    end

    // State is itself a register, so busy has no combinational path from inputs.
    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq: stimulus pushes expected results into a
// scoreboard queue, and an independent monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start   = 1'b0;
    logic [19:0] bin_in  = '0;
    logic        busy;
    logic        done;
    logic [23:0] bcd_out;
    logic        overflow;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    bin_to_bcd_seq dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd_out",    {8'h0, bcd_out}, {8'h0, e.bcd});
                check("overflow",   {31'h0, overflow}, {31'h0, e.ovf});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [19:0] v, input logic [23:0] exp_bcd, input logic exp_ovf);
        start  = 1'b1;
        bin_in = v;
        sb.push_back('{exp_bcd, exp_ovf, cyc + 21});
    endtask

    task automatic wait_idle();
        bool_loop: for (int i = 0; i < 80; i++) begin
            tick();
            if (!busy && !done && sb.size() == 0) return;
        end
        check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic convert(input logic [19:0] v, input logic [23:0] exp_bcd, input logic exp_ovf);
        tick();
        issue(v, exp_bcd, exp_ovf);
        tick();
        start = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'd1);
        wait_idle();
    endtask

    initial begin
        int s;

        // Reset held together with start: reset wins, nothing is accepted.
        start  = 1'b1;
        bin_in = 20'd5;
        repeat (3) tick();
        sys_rst = 1'b0;
        start   = 1'b0;
        tick();
        check("rst_busy",     {31'h0, busy},     32'd0);
        check("rst_done",     {31'h0, done},     32'd0);
        check("rst_bcd",      {8'h0, bcd_out},   32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);

        // Zero input: busy for exactly 20 cycles, done at cycle 20.
        issue(20'd0, 24'h000000, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            check("busy_window", {31'h0, busy}, 32'd1);
        end
        tick();
        check("busy_cleared", {31'h0, busy}, 32'd0);
        wait_idle();

        // Mid-range value, then result must hold across 50 idle cycles.
        convert(20'd123456, 24'h123456, 1'b0);
        for (int k = 0; k < 50; k++) begin
            tick();
            check("hold_bcd", {8'h0, bcd_out}, 32'h123456);
        end

        // Saturation boundary.
        convert(20'd999999,  24'h999999, 1'b0);
        convert(20'd1000000, 24'h999999, 1'b1);
        convert(20'd1048575, 24'h999999, 1'b1);
        convert(20'd7,       24'h000007, 1'b0);

        // start pulses while busy are ignored.
        tick();
        issue(20'd42, 24'h000042, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("busy_ignore", {31'h0, busy}, 32'd1);
            start  = (k == 5 || k == 19);
            bin_in = (k == 5 || k == 19) ? 20'd777777 : 20'd42;
        end
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_requeue", {31'h0, busy}, 32'd0);
        end

        // Back-to-back with start held: done pulses 21 cycles apart.
        tick();
        s = cyc;
        issue(20'd100, 24'h000100, 1'b0);
        sb.push_back('{24'h000200, 1'b0, s + 42});
        tick();
        bin_in = 20'd200;
        while (cyc < s + 22) tick();
        start = 1'b0;
        wait_idle();

        // Reset mid-conversion aborts without done, then a fresh conversion works.
        convert(20'd555555, 24'h555555, 1'b0);
        tick();
        s = cyc;
        start  = 1'b1;
        bin_in = 20'd314159;
        tick();
        start = 1'b0;
        while (cyc < s + 10) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("abort_busy",     {31'h0, busy},     32'd0);
        check("abort_done",     {31'h0, done},     32'd0);
        check("abort_bcd",      {8'h0, bcd_out},   32'd0);
        check("abort_overflow", {31'h0, overflow}, 32'd0);
        repeat (25) tick();
        convert(20'd314159, 24'h314159, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits between the value source (20-bit counter/generator) and the dynamic digit scanner feeding the 595 chain.
- Converts a 20-bit unsigned value into 6 packed BCD digits with a start/busy/done handshake.
- Values above 999999 saturate to 999999 and are flagged.

Parameters:
BIN_W, 20, width of binary input; also the number of SHIFT cycles.
DIGITS, 6, number of BCD output digits (4 bits each).
BCD_MAX, 20'd999_999, largest representable value; must equal 10^DIGITS-1 and fit in BIN_W.

Ports:
sys_clk  input  1  system clock, all logic on rising edge.
sys_rst  input  1  synchronous reset, active-high.
start  input  1  request conversion; sampled only in IDLE.
bin_in  input  BIN_W  unsigned value; captured on the cycle start is accepted.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd_out/overflow update.
bcd_out  output  4*DIGITS  packed BCD, digit 0 in [3:0]; held between conversions.
overflow  output  1  result saturated; held with bcd_out.

Behaviour:
- Reset (sys_rst=1 at a rising edge): state=IDLE; busy=0, done=0, bcd_out=0, overflow=0, shift counter=0, accumulators cleared.
- Reset mid-conversion aborts the conversion:
  - No done pulse.
  - bcd_out and overflow go to 0.
- State IDLE:
  - busy=0.
  - On edge 0 with start=1:
    - Capture bin_in into the binary shift register.
    - Clear the BCD accumulator and counter.
    - Latch ovf_pend=(bin_in>BCD_MAX).
    - Go to SHIFT; busy=1 after edge 0.
- State SHIFT (edges 1..BIN_W), each edge:
  - For every 4-bit digit of the accumulator, add 3 if it is >=5 (combinational, pre-shift).
  - Shift {accumulator, binary reg} left by 1; binary MSB enters accumulator bit 0.
  - Increment the counter.
- Completion, on edge BIN_W (counter==BIN_W-1 before the edge), in the same edge:
  - Perform the final shift.
  - Load bcd_out: the adjusted/shifted accumulator, or BCD of BCD_MAX (24'h999999) if ovf_pend.
  - overflow=ovf_pend; done=1; busy=0; state=IDLE.
- Latency: done is visible exactly BIN_W (20) cycles after the start-accept edge.
  - done is high for exactly 1 cycle.
- start while busy=1: ignored, no queuing; bin_in changes during SHIFT have no effect.
- Back-to-back: start held high through done is accepted on the first IDLE cycle (edge after done).
  - Sustained throughput is one result per BIN_W+1 cycles.
- Accumulator width:
  - Internal accumulator is 4*DIGITS+4 bits so that values up to 2^BIN_W-1 convert without corruption before saturation.
  - The top digit is discarded when overflow is 0.
- bcd_out/overflow change only on done (or reset); no glitches between conversions.
- All outputs are registered; no combinational path from inputs to outputs.
- Simultaneous reset and start: reset wins, and start is not accepted.

Test Plan:
- Reset, then start with bin_in=0 → busy high 20 cycles; done pulse at cycle 20; bcd_out=24'h000000, overflow=0.
- start with bin_in=123456 → done after 20 cycles; bcd_out=24'h123456, overflow=0; bcd_out held for 50 idle cycles afterward.
- bin_in=999999 → bcd_out=24'h999999, overflow=0. Then bin_in=1000000 → bcd_out=24'h999999, overflow=1. Then bin_in=1048575 → 24'h999999, overflow=1.
- Start with 000042, then pulse start with 777777 at cycles 5 and 19 (busy) → single done with bcd_out=24'h000042; second start ignored; busy never re-asserts early.
- start held high continuously, bin_in=000100 then 000200 → done pulses spaced exactly 21 cycles; results 24'h000100, 24'h000200.
- Complete a 555555 conversion, then start 314159 and assert sys_rst for 1 cycle at cycle 10 → no done; bcd_out=0, overflow=0, busy=0 next cycle. A fresh start with 314159 then yields 24'h314159 after 20 cycles.
